// File: rtl/dec_pkg.sv
// Shared encodings for the decode/hazard block: opcodes, functs, ALU and branch codes,
// and the in-flight destination record used by the tracking pipe.
package dec_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] REG_LINK = 5'd31;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLT  = 5'd6,
        ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10,
        ALU_SLLV = 5'd11,
        ALU_SRLV = 5'd12,
        ALU_SRAV = 5'd13,
        ALU_LUI  = 5'd14
    } alu_op_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4,
        BR_BLTZ = 4'd5,
        BR_BGEZ = 4'd6,
        BR_J    = 4'd7,
        BR_JAL  = 4'd8,
        BR_JR   = 4'd9
    } br_op_e;

    typedef struct packed {
        logic       we;
        logic [4:0] wa;
        logic       load;
    } track_t;

    // $0 is never a real destination, so an entry writing it never matches.
    function automatic logic trk_hits(input track_t t, input logic [4:0] addr);
        return t.we && (t.wa != 5'd0) && (t.wa == addr);
    endfunction

endpackage

// File: rtl/dec_num_extend.sv
// 16-to-32 bit immediate extender: sign extension when i_sign is set, zero extension otherwise.
module dec_num_extend (
    input  logic [15:0] i_imm,
    input  logic        i_sign,
    output logic [31:0] o_num
);

    assign o_num = i_sign ? {{16{i_imm[15]}}, i_imm} : {16'b0, i_imm};

endmodule

// File: rtl/dec_ctrl_hazard.sv
// Decode-stage control for the 5-stage MIPS pipe: decode, immediate extension, E/M/W
// destination tracking with forwarding and stall. Build macro DEC_FORWARD_EN enables forwarding.
module dec_ctrl_hazard
    import dec_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_inst,
    input  logic        i_flush,
    input  logic [31:0] i_rd1,
    input  logic [31:0] i_rd2,
    input  logic [31:0] i_aluOutE,
    input  logic [31:0] i_resultM,
    input  logic [31:0] i_rstW,
    output logic        o_sA0,
    output logic        o_sA,
    output logic        o_sB,
    output logic        o_sWRD,
    output logic        o_sByte,
    output logic        o_sLoad,
    output logic        o_regWe,
    output logic        o_dMemWe,
    output logic [4:0]  o_aluOP,
    output logic [3:0]  o_brOP,
    output logic [4:0]  o_WRA,
    output logic [31:0] o_num,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    output logic        o_pause
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic        we_raw, s_imme, sign;
    logic [15:0] imm;
    alu_op_e     alu_op;
    br_op_e      br_op;
    logic        pause;
    track_t      trk_e_d, trk_e_q, trk_m_d, trk_m_q, trk_w_d, trk_w_q;

    assign opcode = i_inst[31:26];
    assign rs     = i_inst[25:21];
    assign rt     = i_inst[20:16];
    assign rd     = i_inst[15:11];
    assign sa     = i_inst[10:6];
    assign funct  = i_inst[5:0];

    always_comb begin
        o_sA0    = 1'b0;
        o_sA     = 1'b0;
        o_sB     = 1'b0;
        o_sWRD   = 1'b0;
        o_sByte  = 1'b0;
        o_sLoad  = 1'b0;
        o_dMemWe = 1'b0;
        we_raw   = 1'b0;
        s_imme   = 1'b0;
        sign     = 1'b0;
        alu_op   = ALU_ADD;
        br_op    = BR_NONE;
        if (i_inst != 32'd0) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_ADDU: we_raw = 1'b1;
                        FN_SUBU: begin alu_op = ALU_SUB;  we_raw = 1'b1; end
                        FN_AND:  begin alu_op = ALU_AND;  we_raw = 1'b1; end
                        FN_OR:   begin alu_op = ALU_OR;   we_raw = 1'b1; end
                        FN_XOR:  begin alu_op = ALU_XOR;  we_raw = 1'b1; end
                        FN_NOR:  begin alu_op = ALU_NOR;  we_raw = 1'b1; end
                        FN_SLT:  begin alu_op = ALU_SLT;  we_raw = 1'b1; end
                        FN_SLTU: begin alu_op = ALU_SLTU; we_raw = 1'b1; end
                        FN_SLLV: begin alu_op = ALU_SLLV; we_raw = 1'b1; end
                        FN_SRLV: begin alu_op = ALU_SRLV; we_raw = 1'b1; end
                        FN_SRAV: begin alu_op = ALU_SRAV; we_raw = 1'b1; end
                        // Constant shifts: A takes rt, B takes the zero-extended shamt.
                        FN_SLL, FN_SRL, FN_SRA: begin
                            o_sA0  = 1'b1;
                            o_sB   = 1'b1;
                            s_imme = 1'b1;
                            we_raw = 1'b1;
                            case (funct)
                                FN_SLL:  alu_op = ALU_SLL;
                                FN_SRL:  alu_op = ALU_SRL;
                                default: alu_op = ALU_SRA;
                            endcase
                        end
                        FN_JR:   br_op = BR_JR;
                        FN_JALR: begin br_op = BR_JR; o_sA = 1'b1; we_raw = 1'b1; end
                        default: ;
                    endcase
                end
                OP_ADDIU: begin o_sB = 1'b1; sign = 1'b1; we_raw = 1'b1; end
                OP_SLTI:  begin alu_op = ALU_SLT;  o_sB = 1'b1; sign = 1'b1; we_raw = 1'b1; end
                OP_SLTIU: begin alu_op = ALU_SLTU; o_sB = 1'b1; sign = 1'b1; we_raw = 1'b1; end
                OP_ANDI:  begin alu_op = ALU_AND;  o_sB = 1'b1; we_raw = 1'b1; end
                OP_ORI:   begin alu_op = ALU_OR;   o_sB = 1'b1; we_raw = 1'b1; end
                OP_XORI:  begin alu_op = ALU_XOR;  o_sB = 1'b1; we_raw = 1'b1; end
                OP_LUI:   begin alu_op = ALU_LUI;  o_sB = 1'b1; we_raw = 1'b1; end
                OP_LW, OP_LB, OP_LBU: begin
                    o_sB    = 1'b1;
                    sign    = 1'b1;
                    we_raw  = 1'b1;
                    o_sWRD  = 1'b1;
                    o_sLoad = 1'b1;
                    o_sByte = (opcode != OP_LW);
                end
                OP_SW, OP_SB: begin
                    o_sB     = 1'b1;
                    sign     = 1'b1;
                    o_dMemWe = 1'b1;
                    o_sByte  = (opcode == OP_SB);
                end
                OP_BEQ:  begin br_op = BR_BEQ;  sign = 1'b1; end
                OP_BNE:  begin br_op = BR_BNE;  sign = 1'b1; end
                OP_BLEZ: begin br_op = BR_BLEZ; sign = 1'b1; end
                OP_BGTZ: begin br_op = BR_BGTZ; sign = 1'b1; end
                OP_REGIMM: begin
                    if (rt == 5'd0) begin
                        br_op = BR_BLTZ;
                        sign  = 1'b1;
                    end else if (rt == 5'd1) begin
                        br_op = BR_BGEZ;
                        sign  = 1'b1;
                    end
                end
                OP_J:    br_op = BR_J;
                OP_JAL:  begin br_op = BR_JAL; o_sA = 1'b1; we_raw = 1'b1; end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (opcode == OP_JAL) begin
            o_WRA = REG_LINK;
        end else if (opcode == OP_RTYPE) begin
            o_WRA = rd;
        end else begin
            o_WRA = rt;
        end
    end

    assign o_regWe = we_raw && (o_WRA != 5'd0);
    assign o_aluOP = alu_op;
    assign o_brOP  = br_op;
    assign imm     = s_imme ? {11'b0, sa} : i_inst[15:0];

    dec_num_extend u_num_extend (
        .i_imm  (imm),
        .i_sign (sign),
        .o_num  (o_num)
    );

`ifdef DEC_FORWARD_EN
    // An E-stage load has no data yet, so it is skipped here and covered by the stall.
    function automatic logic [31:0] fwd_operand(input logic [4:0] addr, input logic [31:0] rf_val);
        if (addr == 5'd0) begin
            return rf_val;
        end else if (trk_hits(trk_e_q, addr) && !trk_e_q.load) begin
            return i_aluOutE;
        end else if (trk_hits(trk_m_q, addr)) begin
            return i_resultM;
        end else if (trk_hits(trk_w_q, addr)) begin
            return i_rstW;
        end
        return rf_val;
    endfunction

    assign pause = trk_e_q.load && (trk_hits(trk_e_q, rs) || trk_hits(trk_e_q, rt));
    assign o_rd1 = fwd_operand(rs, i_rd1);
    assign o_rd2 = fwd_operand(rt, i_rd2);
`else
    assign pause = trk_hits(trk_e_q, rs) || trk_hits(trk_e_q, rt) ||
                   trk_hits(trk_m_q, rs) || trk_hits(trk_m_q, rt) ||
                   trk_hits(trk_w_q, rs) || trk_hits(trk_w_q, rt);
    assign o_rd1 = i_rd1;
    assign o_rd2 = i_rd2;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{i_aluOutE, i_resultM, i_rstW, trk_m_q.load, trk_w_q.load};

    assign o_pause = pause;

    always_comb begin
        trk_e_d = '0;
        if (!pause && !i_flush) begin
            trk_e_d.we   = o_regWe;
            trk_e_d.wa   = o_WRA;
            trk_e_d.load = o_sLoad;
        end
        trk_m_d = trk_e_q;
        trk_w_d = trk_m_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trk_e_q <= '0;
            trk_m_q <= '0;
            trk_w_q <= '0;
        end else begin
            trk_e_q <= trk_e_d;
            trk_m_q <= trk_m_d;
            trk_w_q <= trk_w_d;
        end
    end

endmodule

// File: tb/tb_dec_ctrl_hazard.sv
// Self-checking bench for dec_ctrl_hazard: directed decode vectors, hazard scenarios and a
// randomized run against an instruction-history reference model.
module tb_dec_ctrl_hazard;
    import dec_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] i_inst;
    logic        i_flush;
    logic [31:0] i_rd1, i_rd2, i_aluOutE, i_resultM, i_rstW;
    logic        o_sA0, o_sA, o_sB, o_sWRD, o_sByte, o_sLoad, o_regWe, o_dMemWe;
    logic [4:0]  o_aluOP;
    logic [3:0]  o_brOP;
    logic [4:0]  o_WRA;
    logic [31:0] o_num, o_rd1, o_rd2;
    logic        o_pause;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DEC_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] I_LW8    = 32'h8D28_0000; // LW   $8,0($9)
    localparam logic [31:0] I_USE8   = 32'h0108_5021; // ADDU $10,$8,$8
    localparam logic [31:0] I_ADDU1  = 32'h0043_0821; // ADDU $1,$2,$3
    localparam logic [31:0] I_SUBU1  = 32'h0021_1023; // SUBU $2,$1,$1
    localparam logic [31:0] I_ADDU0  = 32'h0043_0021; // ADDU $0,$2,$3
    localparam logic [31:0] I_SUBU0  = 32'h0000_1023; // SUBU $2,$0,$0
    localparam logic [31:0] I_USE10  = 32'h0140_5821; // ADDU $11,$10,$0

    dec_ctrl_hazard dut (
        .clk(clk), .rstn(rstn), .i_inst(i_inst), .i_flush(i_flush),
        .i_rd1(i_rd1), .i_rd2(i_rd2), .i_aluOutE(i_aluOutE), .i_resultM(i_resultM),
        .i_rstW(i_rstW), .o_sA0(o_sA0), .o_sA(o_sA), .o_sB(o_sB), .o_sWRD(o_sWRD),
        .o_sByte(o_sByte), .o_sLoad(o_sLoad), .o_regWe(o_regWe), .o_dMemWe(o_dMemWe),
        .o_aluOP(o_aluOP), .o_brOP(o_brOP), .o_WRA(o_WRA), .o_num(o_num),
        .o_rd1(o_rd1), .o_rd2(o_rd2), .o_pause(o_pause)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference history: one record per clock that entered E, newest first.
    typedef struct { bit we; int wa; bit ld; } ent_t;
    ent_t hist[$];

    function automatic ent_t hist_at(int idx);
        ent_t none = '{we: 1'b0, wa: 0, ld: 1'b0};
        if (idx < hist.size()) return hist[idx];
        return none;
    endfunction

    function automatic bit writes(ent_t e, int a);
        return e.we && (e.wa != 0) && (e.wa == a);
    endfunction

    function automatic bit ref_pause(int a_rs, int a_rt);
        if (FWD) return hist_at(0).ld && (writes(hist_at(0), a_rs) || writes(hist_at(0), a_rt));
        for (int k = 0; k < 3; k++)
            if (writes(hist_at(k), a_rs) || writes(hist_at(k), a_rt)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_operand(int a, logic [31:0] rf);
        if (!FWD || a == 0) return rf;
        if (writes(hist_at(0), a) && !hist_at(0).ld) return i_aluOutE;
        if (writes(hist_at(1), a)) return i_resultM;
        if (writes(hist_at(2), a)) return i_rstW;
        return rf;
    endfunction

    task automatic set_data();
        i_rd1 = 32'h1111_0001; i_rd2 = 32'h2222_0002; i_aluOutE = 32'hAAAA_000E;
        i_resultM = 32'hBBBB_000B; i_rstW = 32'hCCCC_000C;
    endtask

    task automatic do_reset();
        rstn = 1'b0; i_inst = 32'd0; i_flush = 1'b0; set_data();
        @(posedge clk); #1;
        rstn = 1'b1;
        hist.delete();
    endtask

    task automatic next_cycle(input logic [31:0] inst, input logic flush);
        @(posedge clk); #1;
        i_inst = inst; i_flush = flush; #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; i_flush = 1'b0; set_data(); i_inst = I_USE8; #3;
        n_checks++;
        if (o_pause !== 1'b0) begin n_fail++; $display("FAIL reset_pause: got %b want 0", o_pause); end
        n_checks++;
        if (o_rd1 !== i_rd1) begin n_fail++; $display("FAIL reset_rd1: got %h want %h", o_rd1, i_rd1); end
        i_inst = 32'd0; #1;
        n_checks++;
        if ({o_regWe, o_dMemWe, o_brOP, o_aluOP} !== {1'b0, 1'b0, 4'd0, 5'(ALU_ADD)}) begin
            n_fail++;
            $display("FAIL reset_nop: got we=%b mwe=%b br=%0d alu=%0d want 0/0/0/ADD",
                     o_regWe, o_dMemWe, o_brOP, o_aluOP);
        end
        @(posedge clk); #1; rstn = 1'b1;
    endtask

    typedef struct {
        logic [31:0] inst; logic [7:0] sel; logic [4:0] alu; logic [3:0] br;
        logic [4:0] wra; logic [31:0] num; string name;
    } dec_vec_t;

    task automatic test_decode();
        // sel = {sA0,sA,sB,sWRD,sByte,sLoad,regWe,dMemWe}
        dec_vec_t v[$] = '{
            '{32'h2402FFFF, 8'b0010_0010, ALU_ADD,  BR_NONE, 5'd2,  32'hFFFF_FFFF, "addiu"},
            '{32'h34038000, 8'b0010_0010, ALU_OR,   BR_NONE, 5'd3,  32'h0000_8000, "ori"},
            '{32'h000520C0, 8'b1010_0010, ALU_SLL,  BR_NONE, 5'd4,  32'h0000_0003, "sll"},
            '{32'h0C000010, 8'b0100_0010, ALU_ADD,  BR_JAL,  5'd31, 32'h0000_0010, "jal"},
            '{32'h04610004, 8'b0000_0000, ALU_ADD,  BR_BGEZ, 5'd1,  32'h0000_0004, "bgez"},
            '{32'h04600004, 8'b0000_0000, ALU_ADD,  BR_BLTZ, 5'd0,  32'h0000_0004, "bltz"},
            '{32'h8D280000, 8'b0011_0110, ALU_ADD,  BR_NONE, 5'd8,  32'h0000_0000, "lw"},
            '{32'h8128FFFC, 8'b0011_1110, ALU_ADD,  BR_NONE, 5'd8,  32'hFFFF_FFFC, "lb"},
            '{32'hA128FFFC, 8'b0010_1001, ALU_ADD,  BR_NONE, 5'd8,  32'hFFFF_FFFC, "sb"},
            '{32'h00430021, 8'b0000_0000, ALU_ADD,  BR_NONE, 5'd0,  32'h0000_0021, "addu_r0"},
            '{32'hFC000000, 8'b0000_0000, ALU_ADD,  BR_NONE, 5'd0,  32'h0000_0000, "unknown"},
            '{32'h3C051234, 8'b0010_0010, ALU_LUI,  BR_NONE, 5'd5,  32'h0000_1234, "lui"},
            '{32'h03E00008, 8'b0000_0000, ALU_ADD,  BR_JR,   5'd0,  32'h0000_0008, "jr"},
            '{32'h00000000, 8'b0000_0000, ALU_ADD,  BR_NONE, 5'd0,  32'h0000_0000, "nop"},
            '{32'h30E6FFFF, 8'b0010_0010, ALU_AND,  BR_NONE, 5'd6,  32'h0000_FFFF, "andi"},
            '{32'h016A4807, 8'b0000_0010, ALU_SRAV, BR_NONE, 5'd9,  32'h0000_4807, "srav"},
            '{32'h0080F809, 8'b0100_0010, ALU_ADD,  BR_JR,   5'd31, 32'h0000_F809, "jalr"}
        };
        do_reset();
        foreach (v[k]) begin
            logic [7:0] sel_got;
            i_inst = v[k].inst; #1;
            sel_got = {o_sA0, o_sA, o_sB, o_sWRD, o_sByte, o_sLoad, o_regWe, o_dMemWe};
            n_checks++;
            if ({sel_got, o_aluOP, o_brOP, o_WRA, o_num} !==
                {v[k].sel, v[k].alu, v[k].br, v[k].wra, v[k].num}) begin
                n_fail++;
                $display("FAIL decode_%s: got sel=%b alu=%0d br=%0d wra=%0d num=%h want sel=%b alu=%0d br=%0d wra=%0d num=%h",
                         v[k].name, sel_got, o_aluOP, o_brOP, o_WRA, o_num,
                         v[k].sel, v[k].alu, v[k].br, v[k].wra, v[k].num);
            end
        end
    endtask

    task automatic test_load_use();
        int stalls = 0;
        do_reset();
        next_cycle(I_LW8, 1'b0);
        n_checks++;
        if (o_pause !== 1'b0) begin n_fail++; $display("FAIL lu_first: got pause=%b want 0", o_pause); end
        next_cycle(I_USE8, 1'b0);
        while (o_pause === 1'b1 && stalls < 10) begin
            stalls++;
            @(posedge clk); #2;
        end
        n_checks++;
        if (stalls != (FWD ? 1 : 3)) begin
            n_fail++; $display("FAIL lu_stall_cycles: got %0d want %0d", stalls, FWD ? 1 : 3);
        end
        n_checks++;
        if ({o_rd1, o_rd2} !== (FWD ? {i_resultM, i_resultM} : {i_rd1, i_rd2})) begin
            n_fail++; $display("FAIL lu_operands: got %h/%h", o_rd1, o_rd2);
        end
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        do_reset();
        next_cycle(I_ADDU1, 1'b0);
        next_cycle(I_SUBU1, 1'b0);
        if (FWD) begin
            n_checks++;
            if ({o_pause, o_rd1, o_rd2} !== {1'b0, i_aluOutE, i_aluOutE}) begin
                n_fail++; $display("FAIL b2b_fwd: got pause=%b %h/%h want 0 %h/%h",
                                   o_pause, o_rd1, o_rd2, i_aluOutE, i_aluOutE);
            end
        end else begin
            while (o_pause === 1'b1 && stalls < 10) begin
                stalls++;
                @(posedge clk); #2;
            end
            n_checks++;
            if (stalls != 3) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 3", stalls); end
        end
        do_reset();
        next_cycle(I_ADDU0, 1'b0);
        next_cycle(I_SUBU0, 1'b0);
        n_checks++;
        if ({o_pause, o_rd1, o_rd2} !== {1'b0, i_rd1, i_rd2}) begin
            n_fail++; $display("FAIL b2b_r0: got pause=%b %h/%h want 0 %h/%h",
                               o_pause, o_rd1, o_rd2, i_rd1, i_rd2);
        end
    endtask

    task automatic test_flush();
        do_reset();
        next_cycle(32'h0043_5021, 1'b1);  // ADDU $10,$2,$3, squashed
        next_cycle(I_USE10, 1'b0);
        n_checks++;
        if ({o_pause, o_rd1} !== {1'b0, i_rd1}) begin
            n_fail++; $display("FAIL flush_bubble: got pause=%b rd1=%h want 0 %h", o_pause, o_rd1, i_rd1);
        end
        do_reset();
        next_cycle(I_LW8, 1'b0);
        next_cycle(I_USE8, 1'b1);
        n_checks++;
        if (o_pause !== 1'b1) begin n_fail++; $display("FAIL flush_pause_comb: got %b want 1", o_pause); end
        next_cycle(I_USE10, 1'b0);
        n_checks++;
        if ({o_pause, o_rd1} !== {1'b0, i_rd1}) begin
            n_fail++; $display("FAIL flush_pause_bubble: got pause=%b rd1=%h want 0 %h", o_pause, o_rd1, i_rd1);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        next_cycle(I_LW8, 1'b0);
        next_cycle(I_USE8, 1'b0);
        n_checks++;
        if (o_pause !== 1'b1) begin n_fail++; $display("FAIL mid_stall_pre: got %b want 1", o_pause); end
        #1 rstn = 1'b0; #1;
        n_checks++;
        if (o_pause !== 1'b0) begin n_fail++; $display("FAIL mid_stall_reset: got %b want 0", o_pause); end
        @(posedge clk); #1; rstn = 1'b1; #1;
        n_checks++;
        if (o_pause !== 1'b0) begin n_fail++; $display("FAIL mid_stall_after: got %b want 0", o_pause); end
        hist.delete();
    endtask

    task automatic test_random();
        logic [31:0] inst = 32'd0;
        bit m_we = 1'b0, m_ld = 1'b0, hold = 1'b0;
        int m_wa = 0, a_rs = 0, a_rt = 0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit e_pause, flush;
            ent_t e;
            @(posedge clk); #1;
            if (!hold) begin
                logic [4:0] rs, rt, rd;
                logic [15:0] imm;
                rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3)); imm = 16'($urandom);
                a_rs = int'(rs); a_rt = int'(rt); m_ld = 1'b0;
                case ($urandom_range(0, 5))
                    0: begin inst = {6'h00, rs, rt, rd, 5'd0, 6'h21}; m_we = rd != 0; m_wa = int'(rd); end
                    1: begin inst = {6'h09, rs, rt, imm}; m_we = rt != 0; m_wa = int'(rt); end
                    2: begin inst = {6'h23, rs, rt, imm}; m_we = rt != 0; m_wa = int'(rt); m_ld = 1'b1; end
                    3: begin inst = {6'h2B, rs, rt, imm}; m_we = 1'b0; m_wa = int'(rt); end
                    4: begin inst = {6'h04, rs, rt, imm}; m_we = 1'b0; m_wa = int'(rt); end
                    default: begin inst = 32'd0; m_we = 1'b0; m_wa = 0; a_rs = 0; a_rt = 0; end
                endcase
            end
            flush = ($urandom_range(0, 7) == 0);
            i_inst = inst; i_flush = flush;
            i_rd1 = $urandom; i_rd2 = $urandom; i_aluOutE = $urandom;
            i_resultM = $urandom; i_rstW = $urandom;
            #1;
            e_pause = ref_pause(a_rs, a_rt);
            n_checks++;
            if (o_pause !== e_pause) begin
                n_fail++; $display("FAIL rnd_pause cyc=%0d inst=%h: got %b want %b", cyc, inst, o_pause, e_pause);
            end
            n_checks++;
            if (o_rd1 !== ref_operand(a_rs, i_rd1)) begin
                n_fail++; $display("FAIL rnd_rd1 cyc=%0d: got %h want %h", cyc, o_rd1, ref_operand(a_rs, i_rd1));
            end
            n_checks++;
            if (o_rd2 !== ref_operand(a_rt, i_rd2)) begin
                n_fail++; $display("FAIL rnd_rd2 cyc=%0d: got %h want %h", cyc, o_rd2, ref_operand(a_rt, i_rd2));
            end
            n_checks++;
            if (o_regWe !== m_we || (m_we && o_WRA !== 5'(m_wa))) begin
                n_fail++; $display("FAIL rnd_dest cyc=%0d: got we=%b wra=%0d want we=%b wra=%0d",
                                   cyc, o_regWe, o_WRA, m_we, m_wa);
            end
            e.we = (e_pause || flush) ? 1'b0 : m_we;
            e.wa = m_wa;
            e.ld = m_ld;
            hist.push_front(e);
            if (hist.size() > 3) void'(hist.pop_back());
            hold = e_pause && !flush;
        end
    endtask

    initial begin
        rstn = 1'b0; i_inst = 32'd0; i_flush = 1'b0; set_data();
        test_reset();
        test_decode();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
